// File: rtl/layer0_pkg.sv
// Shared types and Q-format constants for the layer-0 neuron datapath.
// FRAC fractional bits, so ONE is 1.0 and HALF is 0.5 in fixed point.
package layer0_pkg;

  localparam int DW_DEF       = 8;
  localparam int FRAC         = 4;
  localparam int ONE          = 1 << FRAC;
  localparam int HALF         = 1 << (FRAC - 1);
  localparam int N_INPUTS_DEF = 2;

  typedef logic signed [DW_DEF-1:0] fix_t;

  typedef enum logic {
    RELU = 1'b0,
    HSIG = 1'b1
  } act_mode_e;

endpackage

// File: rtl/layer0_act.sv
// Combinational activation for one lane: ReLU or hard sigmoid
// clamp((z >>> 2) + HALF, 0, ONE), evaluated one bit wider so the add cannot wrap.
module layer0_act
  import layer0_pkg::*;
#(
  parameter act_mode_e MODE = RELU,
  parameter int        DW   = DW_DEF,
  parameter int        FRAC = layer0_pkg::FRAC
) (
  input  logic signed [DW-1:0] z,
  output logic signed [DW-1:0] a
);

  localparam int ONE_I  = 1 << FRAC;
  localparam int HALF_I = 1 << (FRAC - 1);

  generate
    if (MODE == HSIG) begin : g_hsig
      logic signed [DW:0] wide;
      logic signed [DW:0] sum;

      always_comb begin
        wide = $signed({z[DW-1], z}) >>> 2;
        sum  = wide + $signed((DW+1)'(HALF_I));
        a    = '0;
        if (sum < 0) begin
          a = '0;
        end else if (sum > $signed((DW+1)'(ONE_I))) begin
          a = DW'(ONE_I);
        end else begin
          a = sum[DW-1:0];
        end
      end
    end else begin : g_relu
      always_comb begin
        a = '0;
        if (!z[DW-1]) begin
          a = z;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/layer0_counter.sv
// Counts MAC acknowledges per neuron evaluation and drives two activation lanes.
// Lane 1 is a hard sigmoid when LAYER0_SIGMOID_EN is defined, ReLU otherwise.
module layer0_counter
  import layer0_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int DW       = DW_DEF,
  parameter int FRAC     = layer0_pkg::FRAC,
  localparam int CW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ack,
  output logic                 ack_mac,
  output logic [CW-1:0]        count,
  input  logic signed [DW-1:0] z_value0,
  input  logic signed [DW-1:0] z_value1,
  output logic signed [DW-1:0] a0,
  output logic signed [DW-1:0] a1
);

`ifdef LAYER0_SIGMOID_EN
  localparam act_mode_e LANE1_MODE = HSIG;
`else
  localparam act_mode_e LANE1_MODE = RELU;
`endif

  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

  logic last_ack;

  assign last_ack = ack && (count == LAST);

  // An ack coincident with ack_mac belongs to the next group, so no
  // gating on ack_mac here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      ack_mac <= 1'b0;
    end else begin
      ack_mac <= last_ack;
      if (last_ack) begin
        count <= '0;
      end else if (ack) begin
        count <= count + 1'b1;
      end
    end
  end

  layer0_act #(
    .MODE (RELU),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_act0 (
    .z (z_value0),
    .a (a0)
  );

  layer0_act #(
    .MODE (LANE1_MODE),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_act1 (
    .z (z_value1),
    .a (a1)
  );

endmodule

// File: tb/tb_layer0_counter.sv
// Directed self-checking bench for layer0_counter (N_INPUTS=2, Q4.4).
// Inputs change #1 after the rising edge; outputs are checked at that point too.
module tb_layer0_counter;

  logic              clk = 1'b0;
  logic              rst;
  logic              ack;
  logic              ack_mac;
  logic [0:0]        count;
  logic signed [7:0] z_value0;
  logic signed [7:0] z_value1;
  logic signed [7:0] a0;
  logic signed [7:0] a1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer0_counter #(
    .N_INPUTS (2),
    .DW       (8),
    .FRAC     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ack      (ack),
    .ack_mac  (ack_mac),
    .count    (count),
    .z_value0 (z_value0),
    .z_value1 (z_value1),
    .a0       (a0),
    .a1       (a1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (count !== 1'b0 || ack_mac !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: count=%0d ack_mac=%0b, expected count=0 ack_mac=0",
                 i, count, ack_mac);
      end
    end
    rst = 1'b1;
    ack = 1'b0;
    step();
    n_checks++;
    if (count !== 1'b0 || ack_mac !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: count=%0d ack_mac=%0b, expected 0/0", count, ack_mac);
    end
  endtask

  task automatic test_group_wrap();
    logic       a_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [0:0] c_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       m_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ack = a_seq[i];
      step();
      n_checks++;
      if (count !== c_exp[i] || ack_mac !== m_exp[i]) begin
        n_fail++;
        $display("FAIL group_wrap cyc%0d: count=%0d ack_mac=%0b, expected count=%0d ack_mac=%0b",
                 i, count, ack_mac, c_exp[i], m_exp[i]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_hold();
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (count !== 1'b1 || ack_mac !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cyc%0d: count=%0d ack_mac=%0b, expected count=1 ack_mac=0",
                 i, count, ack_mac);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [0:0] c_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       m_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (count !== c_exp[i] || ack_mac !== m_exp[i]) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: count=%0d ack_mac=%0b, expected count=%0d ack_mac=%0b",
                 i, count, ack_mac, c_exp[i], m_exp[i]);
      end
    end
    ack = 1'b0;
    step();
    n_checks++;
    if (count !== 1'b0 || ack_mac !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_tail: count=%0d ack_mac=%0b, expected 0/0", count, ack_mac);
    end
  endtask

  task automatic test_reset_mid_group();
    ack = 1'b1;
    step();
    ack = 1'b0;
    rst = 1'b0;
    step();
    n_checks++;
    if (count !== 1'b0 || ack_mac !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: count=%0d ack_mac=%0b, expected 0/0", count, ack_mac);
    end
    rst = 1'b1;
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (count !== 1'b1 || ack_mac !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_after cyc%0d: count=%0d ack_mac=%0b, expected count=1 ack_mac=0",
                 i, count, ack_mac);
      end
      step();
    end
    // Reset on the edge that would have closed the group suppresses ack_mac.
    rst = 1'b0;
    ack = 1'b1;
    step();
    rst = 1'b1;
    ack = 1'b0;
    step();
    n_checks++;
    if (count !== 1'b0 || ack_mac !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_on_last_ack: count=%0d ack_mac=%0b, expected 0/0", count, ack_mac);
    end
  endtask

  task automatic test_relu();
    logic signed [7:0] z_in  [5] = '{8'sd40, -8'sd40, 8'sd0, 8'sd127, -8'sd128};
    logic signed [7:0] a_exp [5] = '{8'sd40, 8'sd0, 8'sd0, 8'sd127, 8'sd0};
    for (int i = 0; i < 5; i++) begin
      z_value0 = z_in[i];
      #1;
      n_checks++;
      if (a0 !== a_exp[i]) begin
        n_fail++;
        $display("FAIL relu z=%0d: a0=%0d, expected %0d", z_in[i], a0, a_exp[i]);
      end
    end
  endtask

  task automatic test_lane1();
`ifdef LAYER0_SIGMOID_EN
    logic signed [7:0] z_in  [7] = '{8'sd0, 8'sd16, 8'sd40, -8'sd40, 8'sd127, -8'sd128, -8'sd4};
    logic signed [7:0] a_exp [7] = '{8'sd8, 8'sd12, 8'sd16, 8'sd0, 8'sd16, 8'sd0, 8'sd7};
    for (int i = 0; i < 7; i++) begin
`else
    logic signed [7:0] z_in  [4] = '{-8'sd40, 8'sd40, 8'sd127, -8'sd128};
    logic signed [7:0] a_exp [4] = '{8'sd0, 8'sd40, 8'sd127, 8'sd0};
    for (int i = 0; i < 4; i++) begin
`endif
      z_value1 = z_in[i];
      #1;
      n_checks++;
      if (a1 !== a_exp[i]) begin
        n_fail++;
        $display("FAIL lane1 z=%0d: a1=%0d, expected %0d", z_in[i], a1, a_exp[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    ack      = 1'b0;
    z_value0 = '0;
    z_value1 = '0;
    #1;
    test_reset();
    test_group_wrap();
    test_hold();
    test_back_to_back();
    test_reset_mid_group();
    test_relu();
    test_lane1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer0_counter.md
LAYER0_COUNTER -- requirements
Module: layer0_counter

Interface
REQ-001 Parameter N_INPUTS, default 2: number of MAC acknowledge pulses that make up one neuron evaluation.
REQ-002 Parameter DW, default 8: data width of the signed activation values.
REQ-003 Parameter FRAC, default 4: number of fractional bits in the Q-format (Q4.4, so 16 = 1.0).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port ack, input, 1 bit: one-cycle pulse meaning one multiply-accumulate step has completed.
REQ-007 Port ack_mac, output, 1 bit: one-cycle pulse meaning all N_INPUTS MAC steps are complete.
REQ-008 Port count, output, clog2(N_INPUTS) bits (minimum 1): current MAC step count, for debug.
REQ-009 Port z_value0, input, DW bits signed: pre-activation value for lane 0.
REQ-010 Port z_value1, input, DW bits signed: pre-activation value for lane 1.
REQ-011 Port a0, output, DW bits signed: activation output for lane 0.
REQ-012 Port a1, output, DW bits signed: activation output for lane 1.

Function
REQ-013 count increments by 1 on every rising edge at which ack=1 and rst=1.
REQ-014 When ack=1 and count==N_INPUTS-1:
- count shall wrap to 0 on that edge;
- ack_mac shall be 1 for exactly the next cycle.
REQ-015 On every other edge with rst=1, ack_mac shall be 0, so the latency is one cycle after the N-th ack is sampled.
REQ-016 Boundary conditions:
- count shall never exceed N_INPUTS-1;
- ack=0 holds count;
- back-to-back ack pulses on consecutive cycles shall each be counted;
- an ack in the same cycle that ack_mac is high shall count toward the next group.
REQ-017 Lane 0 activation is ReLU and is combinational: a0 = z_value0 when z_value0 >= 0, otherwise 0.
REQ-018 Lane 1 activation is combinational and selected by the configuration macro in REQ-022.
REQ-019 All activation arithmetic is signed two's-complement at DW bits.
- Shifts are arithmetic.
- No output shall overflow; all results are clamped to the stated range.

Reset
REQ-020 While rst=0 at a rising edge, count shall be cleared to 0 and ack_mac to 0, and any ack in that cycle shall be ignored.
REQ-021 Reset asserted mid-group shall discard the partial count, and no ack_mac shall be issued for that group.

Configuration
REQ-022 Macro LAYER0_SIGMOID_EN selects the lane 1 function.
- With the macro defined, lane 1 is a hard sigmoid: a1 = clamp((z_value1 >>> 2) + (1 << (FRAC-1)), 0, 1 << FRAC), which in Q4.4 is clamp(z/4 + 8, 0, 16).
- Without the macro, lane 1 is ReLU, identical to REQ-017.

Structure
REQ-023 A shared package layer0_pkg shall hold:
- the typedef for a DW-bit signed fixed-point value;
- the constants FRAC, ONE = 1<<FRAC, and HALF = 1<<(FRAC-1);
- the default for N_INPUTS.
REQ-024 Each activation shall be implemented as one combinational sub-module, layer0_act, with a mode parameter (RELU or HSIG), instantiated once per lane.

Verification
REQ-025 Reset behaviour: hold rst=0 for 3 cycles with ack=1, then release -> count=0 and ack_mac=0 throughout.
REQ-026 Normal group and wrap: with N_INPUTS=2, pulse ack on cycles 5 and 7 -> count=1 after cycle 5, then count=0 and ack_mac=1 during cycle 8 only.
REQ-027 Back-to-back groups: ack held high for 4 consecutive cycles -> ack_mac pulses in the 2nd and 4th following cycles and count alternates 1,0,1,0.
REQ-028 Reset mid-group: one ack, then rst=0 for 1 cycle, then one ack -> count=1 and no ack_mac.
REQ-029 ReLU: z_value0 = 40, -40, 0, 127, -128 -> a0 = 40, 0, 0, 127, 0.
REQ-030 Hard sigmoid (macro defined): z_value1 = 0, 16, 40, -40, 127 -> a1 = 8, 12, 16, 0, 16; without the macro, z_value1 = -40 -> a1 = 0.
